// File: rtl/sn_window_decoder.sv
// Counts 1s of a serial SN bitstream over 2^WIN_LOG2 valid samples. It decodes the count as unipolar or bipolar and registers it with a one-cycle strobe.
// Optional SNDEC_AVG_EN: the result is the floor average of the last 4 window values.
module sn_window_decoder #(
  parameter int WIN_LOG2 = 7,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sn_bit,
  input  logic             sn_valid,
  input  logic             start,
  input  logic             cont,
  input  logic             bipolar,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  output logic             sat,
  output logic             busy
);

  generate
    if (OUT_W < WIN_LOG2 + 1) begin : g_bad_width
      $error("sn_window_decoder: OUT_W must be >= WIN_LOG2+1");
    end
  endgenerate

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]                 state;
  logic [WIN_LOG2-1:0]        bit_cnt;
  logic [WIN_LOG2-1:0]        ones_cnt;
  logic                       last;
  logic [WIN_LOG2:0]          ones_fin;
  logic signed [WIN_LOG2:0]   v_win;
  logic                       sat_win;
  logic signed [WIN_LOG2:0]   emit_v;
  logic                       emit_sat;
  logic                       emit_ok;

  assign busy     = (state == S_ACCUM);
  // start takes priority, so a start on the last-sample cycle discards the window
  assign last     = busy && sn_valid && !start && (bit_cnt == '1);
  assign ones_fin = {1'b0, ones_cnt} + {{WIN_LOG2{1'b0}}, sn_bit};

  always_comb begin
    v_win   = '0;
    sat_win = 1'b0;
    if (ones_fin[WIN_LOG2]) begin
      // a full window of ones exceeds the positive range in both decodes
      v_win   = {1'b0, {WIN_LOG2{1'b1}}};
      sat_win = 1'b1;
    end else if (bipolar) begin
      v_win = $signed({ones_fin[WIN_LOG2-1:0], 1'b0} - {1'b1, {WIN_LOG2{1'b0}}});
    end else begin
      v_win = $signed(ones_fin);
    end
  end

`ifdef SNDEC_AVG_EN
  logic signed [WIN_LOG2:0]   hist [0:2];
  logic [2:0]                 hist_sat;
  logic [1:0]                 hist_cnt;
  logic signed [WIN_LOG2+2:0] avg_sum;

  assign avg_sum  = (WIN_LOG2+3)'(v_win) + (WIN_LOG2+3)'(hist[0])
                  + (WIN_LOG2+3)'(hist[1]) + (WIN_LOG2+3)'(hist[2]);
  assign emit_v   = $signed(avg_sum[WIN_LOG2+2:2]);
  assign emit_sat = sat_win | (|hist_sat);
  assign emit_ok  = (hist_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      hist[0]  <= '0;
      hist[1]  <= '0;
      hist[2]  <= '0;
      hist_sat <= '0;
      hist_cnt <= '0;
    end else if (last) begin
      hist[0]  <= v_win;
      hist[1]  <= hist[0];
      hist[2]  <= hist[1];
      hist_sat <= {hist_sat[1:0], sat_win};
      if (hist_cnt != 2'd3) hist_cnt <= hist_cnt + 2'd1;
    end
  end
`else
  assign emit_v   = v_win;
  assign emit_sat = sat_win;
  assign emit_ok  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      ones_cnt     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      sat          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (start) begin
        state    <= S_ACCUM;
        bit_cnt  <= '0;
        ones_cnt <= '0;
      end else if (busy && sn_valid) begin
        if (last) begin
          bit_cnt  <= '0;
          ones_cnt <= '0;
          if (!cont) state <= S_IDLE;
          if (emit_ok) begin
            result       <= OUT_W'(emit_v);
            sat          <= emit_sat;
            result_valid <= 1'b1;
          end
        end else begin
          bit_cnt  <= bit_cnt + WIN_LOG2'(1);
          ones_cnt <= ones_cnt + WIN_LOG2'(sn_bit);
        end
      end
    end
  end

endmodule

// File: tb/tb_sn_window_decoder.sv
// Directed bench for sn_window_decoder (WIN_LOG2=7, OUT_W=8).
module tb_sn_window_decoder;
  logic       clk = 1'b0;
  logic       rst_n, sn_bit, sn_valid, start, cont, bipolar;
  logic [7:0] result;
  logic       result_valid, sat, busy;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int cyc = 0;
  int t_a;

  sn_window_decoder #(.WIN_LOG2(7), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sn_bit(sn_bit), .sn_valid(sn_valid),
    .start(start), .cont(cont), .bipolar(bipolar), .result(result),
    .result_valid(result_valid), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // drive one cycle, then look at outputs 1ns after the edge
  task automatic step(input logic b, input logic v);
    sn_bit = b;
    sn_valid = v;
    @(posedge clk);
    #1;
    cyc++;
    if (result_valid) strobes++;
  endtask

  // the sample offered alongside start must not be counted
  task automatic do_start();
    start = 1'b1;
    step(1'b1, 1'b1);
    start = 1'b0;
    sn_valid = 1'b0;
  endtask

  task automatic window(input int ones);
    for (int i = 0; i < 128; i++) step(i < ones, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; sn_bit = 1'b0; sn_valid = 1'b0; start = 1'b0;
    cont = 1'b0; bipolar = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_valid", result_valid, 1'b0);
    check("rst_sat", sat, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // idle ignores samples
    strobes = 0;
    for (int i = 0; i < 140; i++) step(1'b1, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_strobes", strobes, 0);

`ifdef SNDEC_AVG_EN
    cont = 1'b1;
    do_start();
    strobes = 0;
    window(0);
    window(32);
    window(64);
    check("avg_no_strobe", strobes, 0);
    window(96);
    check("avg_valid", result_valid, 1'b1);
    check("avg_result", result, 8'd48);
    check("avg_sat", sat, 1'b0);
    check("avg_strobes", strobes, 1);
`else
    // unipolar all ones saturates
    do_start();
    check("t1_busy_start", busy, 1'b1);
    strobes = 0;
    for (int i = 0; i < 127; i++) step(1'b1, 1'b1);
    check("t1_no_early", strobes, 0);
    step(1'b1, 1'b1);
    check("t1_valid", result_valid, 1'b1);
    check("t1_result", result, 8'h7F);
    check("t1_sat", sat, 1'b1);
    check("t1_busy_end", busy, 1'b0);
    step(1'b0, 1'b0);
    check("t1_strobe_1cyc", result_valid, 1'b0);
    check("t1_hold", result, 8'h7F);

    // bipolar
    bipolar = 1'b1;
    do_start();
    window(0);
    check("t2_zero_result", result, 8'h80);
    check("t2_zero_sat", sat, 1'b0);
    do_start();
    window(128);
    check("t2_ones_result", result, 8'h7F);
    check("t2_ones_sat", sat, 1'b1);
    do_start();
    for (int i = 0; i < 128; i++) step(i % 2 == 0, 1'b1);
    check("t2_alt_result", result, 8'h00);
    check("t2_alt_sat", sat, 1'b0);
    bipolar = 1'b0;

    // sparse valid
    do_start();
    strobes = 0;
    for (int i = 0; i < 128; i++) begin
      step(i < 32, 1'b1);
      if (i == 126) check("t3_no_early", strobes, 0);
      if (i < 127) step(1'b1, 1'b0);
    end
    check("t3_valid", result_valid, 1'b1);
    check("t3_result", result, 8'd32);
    check("t3_strobes", strobes, 1);

    // continuous windows
    cont = 1'b1;
    do_start();
    window(32);
    check("t4a_valid", result_valid, 1'b1);
    check("t4a_result", result, 8'd32);
    check("t4a_busy", busy, 1'b1);
    t_a = cyc;
    cont = 1'b0;
    window(96);
    check("t4b_valid", result_valid, 1'b1);
    check("t4b_result", result, 8'd96);
    check("t4_spacing", cyc - t_a, 128);
    check("t4b_busy", busy, 1'b0);

    // restart mid-window and on the last-sample cycle
    do_start();
    strobes = 0;
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1);
    do_start();
    for (int i = 0; i < 128; i++) step(i < 10, 1'b1);
    check("t5_result", result, 8'd10);
    check("t5_strobes", strobes, 1);
    do_start();
    strobes = 0;
    for (int i = 0; i < 127; i++) step(1'b1, 1'b1);
    start = 1'b1;
    step(1'b1, 1'b1);
    start = 1'b0;
    check("t5_start_wins", strobes, 0);
    check("t5_start_busy", busy, 1'b1);
    window(5);
    check("t5_after_result", result, 8'd5);
    check("t5_after_strobes", strobes, 1);

    // reset mid-window
    do_start();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    rst_n = 1'b0;
    step(1'b1, 1'b1);
    check("t5_rst_result", result, 8'h00);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_sat", sat, 1'b0);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
